// File: rtl/gost34_12_2015_pkg.sv
// Shared definitions for the Kuznyechik S-box paths: word type, inverse-builder
// FSM states and the forward substitution pi.
package gost34_12_2015_pkg;

  localparam int SBOX_W = 8;
  localparam int SBOX_N = 1 << SBOX_W;

  typedef logic [SBOX_W-1:0] sbox_word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUILD = 2'd1,
    READY = 2'd2
  } inv_state_t;

  localparam sbox_word_t KUZ_PI [SBOX_N] = '{
    8'hFC, 8'hEE, 8'hDD, 8'h11, 8'hCF, 8'h6E, 8'h31, 8'h16, 8'hFB, 8'hC4, 8'hFA, 8'hDA, 8'h23, 8'hC5, 8'h04, 8'h4D,
    8'hE9, 8'h77, 8'hF0, 8'hDB, 8'h93, 8'h2E, 8'h99, 8'hBA, 8'h17, 8'h36, 8'hF1, 8'hBB, 8'h14, 8'hCD, 8'h5F, 8'hC1,
    8'hF9, 8'h18, 8'h65, 8'h5A, 8'hE2, 8'h5C, 8'hEF, 8'h21, 8'h81, 8'h1C, 8'h3C, 8'h42, 8'h8B, 8'h01, 8'h8E, 8'h4F,
    8'h05, 8'h84, 8'h02, 8'hAE, 8'hE3, 8'h6A, 8'h8F, 8'hA0, 8'h06, 8'h0B, 8'hED, 8'h98, 8'h7F, 8'hD4, 8'hD3, 8'h1F,
    8'hEB, 8'h34, 8'h2C, 8'h51, 8'hEA, 8'hC8, 8'h48, 8'hAB, 8'hF2, 8'h2A, 8'h68, 8'hA2, 8'hFD, 8'h3A, 8'hCE, 8'hCC,
    8'hB5, 8'h70, 8'h0E, 8'h56, 8'h08, 8'h0C, 8'h76, 8'h12, 8'hBF, 8'h72, 8'h13, 8'h47, 8'h9C, 8'hB7, 8'h5D, 8'h87,
    8'h15, 8'hA1, 8'h96, 8'h29, 8'h10, 8'h7B, 8'h9A, 8'hC7, 8'hF3, 8'h91, 8'h78, 8'h6F, 8'h9D, 8'h9E, 8'hB2, 8'hB1,
    8'h32, 8'h75, 8'h19, 8'h3D, 8'hFF, 8'h35, 8'h8A, 8'h7E, 8'h6D, 8'h54, 8'hC6, 8'h80, 8'hC3, 8'hBD, 8'h0D, 8'h57,
    8'hDF, 8'hF5, 8'h24, 8'hA9, 8'h3E, 8'hA8, 8'h43, 8'hC9, 8'hD7, 8'h79, 8'hD6, 8'hF6, 8'h7C, 8'h22, 8'hB9, 8'h03,
    8'hE0, 8'h0F, 8'hEC, 8'hDE, 8'h7A, 8'h94, 8'hB0, 8'hBC, 8'hDC, 8'hE8, 8'h28, 8'h50, 8'h4E, 8'h33, 8'h0A, 8'h4A,
    8'hA7, 8'h97, 8'h60, 8'h73, 8'h1E, 8'h00, 8'h62, 8'h44, 8'h1A, 8'hB8, 8'h38, 8'h82, 8'h64, 8'h9F, 8'h26, 8'h41,
    8'hAD, 8'h45, 8'h46, 8'h92, 8'h27, 8'h5E, 8'h55, 8'h2F, 8'h8C, 8'hA3, 8'hA5, 8'h7D, 8'h69, 8'hD5, 8'h95, 8'h3B,
    8'h07, 8'h58, 8'hB3, 8'h40, 8'h86, 8'hAC, 8'h1D, 8'hF7, 8'h30, 8'h37, 8'h6B, 8'hE4, 8'h88, 8'hD9, 8'hE7, 8'h89,
    8'hE1, 8'h1B, 8'h83, 8'h49, 8'h4C, 8'h3F, 8'hF8, 8'hFE, 8'h8D, 8'h53, 8'hAA, 8'h90, 8'hCA, 8'hD8, 8'h85, 8'h61,
    8'h20, 8'h71, 8'h67, 8'hA4, 8'h2D, 8'h2B, 8'h09, 8'h5B, 8'hCB, 8'h9B, 8'h25, 8'hD0, 8'hBE, 8'hE5, 8'h6C, 8'h52,
    8'h59, 8'hA6, 8'h74, 8'hD2, 8'hE6, 8'hF4, 8'hB4, 8'hC0, 8'hD1, 8'h66, 8'hAF, 8'hC2, 8'h39, 8'h4B, 8'h63, 8'hB6
  };

endpackage

// File: rtl/gost34_12_2015_inv_sbox_ram.sv
// N x W inverse S-box store: synchronous write, registered read.
// The read register is the lookup output, so it holds between lookups.
module gost34_12_2015_inv_sbox_ram
  import gost34_12_2015_pkg::*;
#(
  parameter int W = SBOX_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [W-1:0] waddr,
  input  logic [W-1:0] wdata,
  input  logic         re,
  input  logic [W-1:0] raddr,
  output logic [W-1:0] rdata
);

  localparam int N = 2**W;

  logic [W-1:0] mem_q [N];
  logic [W-1:0] rdata_q;

  // Storage array, one entry written per build cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N; k++) mem_q[k] <= '0;
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read register: captures on a lookup, otherwise keeps the last result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata_q <= '0;
    else if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/gost34_12_2015_inv_sbox_gen.sv
// Inverse Kuznyechik S-box generator.
// state | meaning
// IDLE  | forward table writable, waiting for build_start
// BUILD | walking fwd[0..N-1], filling inv and checking for repeats
// READY | inverse valid, serving lookups
module gost34_12_2015_inv_sbox_gen
  import gost34_12_2015_pkg::*;
#(
  parameter int W = SBOX_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_we,
  input  logic [W-1:0] cfg_addr,
  input  logic [W-1:0] cfg_data,
  input  logic         build_start,
  output logic         busy,
  output logic         done,
  output logic         err_dup,
  input  logic         lk_valid,
  input  logic [W-1:0] lk_in,
  output logic         lk_ready,
  output logic         out_valid,
  output logic [W-1:0] out
);

  localparam int N = 2**W;

  inv_state_t   state_q, state_d;
  logic [W-1:0] i_q, i_d;
  logic         err_q, err_d;
  logic         out_valid_q;
  logic [W-1:0] fwd_q [N];
  logic [N-1:0] seen_q;

  logic [W-1:0] v;
  logic         dup;
  logic         in_build, in_ready;
  logic         fwd_we, start, inv_we, lk_re;

  assign in_build = (state_q == BUILD);
  assign in_ready = (state_q == READY);

  assign v      = fwd_q[i_q];
  assign dup    = seen_q[v];
  assign fwd_we = cfg_we && !in_build;
  // In READY a config write wins over build_start; the table changed, so the user must restart.
  assign start  = build_start && ((state_q == IDLE) || (in_ready && !cfg_we));
  assign inv_we = in_build && !dup;
  assign lk_re  = lk_valid && in_ready;

  // Next-state logic for the FSM, index counter and duplicate flag.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = BUILD;
          i_d     = '0;
          err_d   = 1'b0;
        end
      end
      BUILD: begin
        if (dup) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (&i_q) begin
          state_d = READY;
        end else begin
          i_d = i_q + 1'b1;
        end
      end
      READY: begin
        if (cfg_we) begin
          state_d = IDLE;
        end else if (start) begin
          state_d = BUILD;
          i_d     = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, counter, error flag and lookup-valid registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      i_q         <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      err_q       <= err_d;
      out_valid_q <= lk_re;
    end
  end

  // Forward table, written by software outside of BUILD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N; k++) fwd_q[k] <= '0;
    end else if (fwd_we) begin
      fwd_q[cfg_addr] <= cfg_data;
    end
  end

  // Seen bitmap: cleared on each build start, one bit set per accepted entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         seen_q    <= '0;
    else if (start)  seen_q    <= '0;
    else if (inv_we) seen_q[v] <= 1'b1;
  end

  gost34_12_2015_inv_sbox_ram #(.W(W)) u_inv_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (inv_we),
    .waddr (v),
    .wdata (i_q),
    .re    (lk_re),
    .raddr (lk_in),
    .rdata (out)
  );

  assign busy      = in_build;
  assign done      = in_ready;
  assign lk_ready  = in_ready;
  assign err_dup   = err_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_gost34_12_2015_inv_sbox_gen.sv
// Bench for the inverse S-box generator with a table-level reference model.
module tb_gost34_12_2015_inv_sbox_gen;
  import gost34_12_2015_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_we;
  logic [7:0] cfg_addr, cfg_data;
  logic       build_start;
  logic       busy, done, err_dup;
  logic       lk_valid;
  logic [7:0] lk_in;
  logic       lk_ready, out_valid;
  logic [7:0] out_w;

  int n_run  = 0;
  int n_fail = 0;

  logic [7:0] m_fwd [256];
  logic [7:0] m_inv [256];
  logic [7:0] perm  [256];

  gost34_12_2015_inv_sbox_gen dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .build_start (build_start),
    .busy        (busy),
    .done        (done),
    .err_dup     (err_dup),
    .lk_valid    (lk_valid),
    .lk_in       (lk_in),
    .lk_ready    (lk_ready),
    .out_valid   (out_valid),
    .out         (out_w)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected build outcome: index of the first entry whose value already appeared
  // earlier in the table (-1 for a permutation); also fills the expected inverse.
  function automatic int model_build();
    int first_idx [256];
    for (int y = 0; y < 256; y++) first_idx[y] = -1;
    for (int x = 0; x < 256; x++) begin
      if (first_idx[m_fwd[x]] >= 0) return x;
      first_idx[m_fwd[x]] = x;
    end
    for (int y = 0; y < 256; y++) m_inv[y] = 8'(first_idx[y]);
    return -1;
  endfunction

  task automatic wr(input int a, input int d);
    cfg_we = 1'b1; cfg_addr = 8'(a); cfg_data = 8'(d);
    tick();
    cfg_we = 1'b0;
    m_fwd[a] = 8'(d);
  endtask

  task automatic load_table();
    for (int x = 0; x < 256; x++) wr(x, perm[x]);
  endtask

  // Pulse build_start (optionally with a same-cycle write), count busy cycles,
  // and compare against the model.
  task automatic do_build(input string tag, input bit co_we, input int a, input int d);
    int k, bc;
    build_start = 1'b1;
    if (co_we) begin cfg_we = 1'b1; cfg_addr = 8'(a); cfg_data = 8'(d); end
    tick();
    build_start = 1'b0; cfg_we = 1'b0;
    if (co_we) m_fwd[a] = 8'(d);
    k = model_build();
    check({tag, "_err_clear_at_start"}, err_dup, 0);
    bc = 0;
    while (busy === 1'b1 && bc < 400) begin
      tick();
      bc++;
    end
    check({tag, "_busy_cycles"}, bc, (k < 0) ? 256 : k + 1);
    check({tag, "_done"}, done, (k < 0) ? 1 : 0);
    check({tag, "_err_dup"}, err_dup, (k < 0) ? 0 : 1);
    check({tag, "_lk_ready"}, lk_ready, (k < 0) ? 1 : 0);
  endtask

  task automatic lookup1(input string tag, input int y);
    lk_valid = 1'b1; lk_in = 8'(y);
    tick();
    lk_valid = 1'b0;
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_out"}, out_w, m_inv[y]);
    tick();
    check({tag, "_valid_drop"}, out_valid, 0);
    check({tag, "_out_hold"}, out_w, m_inv[y]);
  endtask

  // Back-to-back lookups: sweep all y in order, or n random y values.
  task automatic lookup_stream(input string tag, input bit sweep, input int n, input bit pi_check);
    int y;
    int bad = 0;
    for (int t = 0; t < n; t++) begin
      y = sweep ? t : int'($urandom_range(0, 255));
      lk_valid = 1'b1; lk_in = 8'(y);
      tick();
      if (out_valid !== 1'b1 || out_w !== m_inv[y]) bad++;
      if (pi_check && KUZ_PI[out_w] !== 8'(y)) bad++;
    end
    lk_valid = 1'b0;
    check({tag, "_stream_errors"}, bad, 0);
  endtask

  task automatic model_reset();
    for (int x = 0; x < 256; x++) m_fwd[x] = 8'h00;
  endtask

  initial begin
    int a, b, j;
    logic [7:0] tmp;
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    build_start = 1'b0; lk_valid = 1'b0; lk_in = '0;
    model_reset();
    repeat (2) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err_dup, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out", out_w, 0);
    check("rst_lk_ready", lk_ready, 0);
    rst = 1'b0;
    tick();

    // Identity table
    for (int x = 0; x < 256; x++) perm[x] = 8'(x);
    load_table();
    do_build("t1", 1'b0, 0, 0);
    lookup1("t1_lk00", 8'h00);
    lookup1("t1_lk7f", 8'h7F);
    lookup1("t1_lkff", 8'hFF);

    // Kuznyechik pi
    for (int x = 0; x < 256; x++) perm[x] = KUZ_PI[x];
    load_table();
    do_build("t2", 1'b0, 0, 0);
    lookup1("t2_fc", 8'hFC);
    check("t2_fc_const", out_w, 8'h00);
    lookup1("t2_ee", 8'hEE);
    check("t2_ee_const", out_w, 8'h01);
    lookup1("t2_b6", 8'hB6);
    check("t2_b6_const", out_w, 8'hFF);
    lookup_stream("t2_sweep", 1'b1, 256, 1'b1);

    // Identity with a duplicate at index 5
    for (int x = 0; x < 256; x++) perm[x] = 8'(x);
    perm[5] = 8'h03;
    load_table();
    do_build("t3_dup", 1'b0, 0, 0);
    lk_valid = 1'b1; lk_in = 8'h10;
    tick();
    lk_valid = 1'b0;
    check("t3_no_lookup", out_valid, 0);
    wr(5, 8'h05);
    do_build("t3_fix", 1'b0, 0, 0);
    lookup1("t3_lk05", 8'h05);

    // Random permutation and random lookups
    for (int x = 0; x < 256; x++) perm[x] = 8'(x);
    for (int x = 255; x > 0; x--) begin
      j = int'($urandom_range(0, x));
      tmp = perm[x]; perm[x] = perm[j]; perm[j] = tmp;
    end
    load_table();
    do_build("rnd_perm", 1'b0, 0, 0);
    lookup_stream("rnd_perm", 1'b0, 200, 1'b0);

    // Random duplicate: copy an earlier entry's value into a later slot
    a = int'($urandom_range(0, 200));
    b = int'($urandom_range(a + 1, 255));
    wr(b, m_fwd[a]);
    do_build("rnd_dup", 1'b0, 0, 0);

    // Reset in the middle of a build
    for (int x = 0; x < 256; x++) perm[x] = 8'(x);
    load_table();
    build_start = 1'b1;
    tick();
    build_start = 1'b0;
    repeat (100) tick();
    check("t4_busy_before", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("t4_busy", busy, 0);
    check("t4_done", done, 0);
    check("t4_err", err_dup, 0);
    check("t4_out_valid", out_valid, 0);
    check("t4_out", out_w, 0);
    #1 rst = 1'b0;
    model_reset();
    tick();
    lk_valid = 1'b1; lk_in = 8'h22;
    tick();
    lk_valid = 1'b0;
    check("t4_no_lookup", out_valid, 0);
    check("t4_idle_done", done, 0);

    // READY: write and lookup in the same cycle
    for (int x = 0; x < 256; x++) perm[x] = KUZ_PI[x];
    load_table();
    do_build("t5", 1'b0, 0, 0);
    cfg_we = 1'b1; cfg_addr = 8'h00; cfg_data = 8'h01;
    lk_valid = 1'b1; lk_in = 8'hFC;
    tick();
    cfg_we = 1'b0;
    m_fwd[0] = 8'h01;
    check("t5_out_valid", out_valid, 1);
    check("t5_out", out_w, 8'h00);
    check("t5_done_drop", done, 0);
    check("t5_lk_ready_drop", lk_ready, 0);
    lk_in = 8'hEE;
    tick();
    lk_valid = 1'b0;
    check("t5_not_accepted", out_valid, 0);
    check("t5_out_held", out_w, 8'h00);

    // IDLE: write and build_start together
    wr(0, 8'hFC);
    wr(255, 8'h00);
    do_build("t6", 1'b1, 255, 8'hB6);
    lookup1("t6_b6", 8'hB6);
    check("t6_b6_const", out_w, 8'hFF);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/gost34_12_2015_inv_sbox_gen.md
Name: gost34_12_2015_inv_sbox_gen

Overview:
Builds and serves the inverse of the GOST 34.12-2015 (Kuznyechik) 8-bit substitution pi, for the decryption path.
- Flow: software loads the forward table entry by entry, pulses build, and the block computes pi^-1 over N cycles while checking that the table is a bijection. It then answers inverse lookups with 1-cycle latency.
- Placement: sits beside the forward S-box lookup in the cipher core; feeds the inverse-S layer of the decryption rounds.

Parameters:
W, 8, S-box word width in bits.
N, 2**W, number of table entries (derived; do not override).

Ports:
clk  input  1  single clock; all state on rising edge.
rst  input  1  asynchronous, active-high reset.
cfg_we  input  1  write one forward-table entry.
cfg_addr  input  W  forward-table index x.
cfg_data  input  W  pi(x).
build_start  input  1  single-cycle pulse; starts the inverse build.
busy  output  1  build in progress.
done  output  1  inverse table valid; lookups permitted.
err_dup  output  1  forward table is not a permutation.
lk_valid  input  1  lookup request.
lk_in  input  W  value y to invert.
lk_ready  output  1  lookup accepted this cycle (= done).
out_valid  output  1  lookup result valid.
out  output  W  pi^-1(y).

Behaviour:
- Reset (asynchronous, active-high):
  - FSM to IDLE.
  - busy, done, err_dup, out_valid, out = 0.
  - Forward table, inverse table, seen bitmap and counter cleared to 0.
  - Reset asserted mid-BUILD aborts the build; done stays 0.
- Storage:
  - fwd[N] of W bits.
  - inv[N] of W bits.
  - seen[N] of 1 bit.
  - Index counter i, W bits.
- FSM states: IDLE, BUILD, READY.
- IDLE:
  - cfg_we writes fwd[cfg_addr] <= cfg_data.
  - build_start: i <= 0, seen <= 0, err_dup <= 0, go to BUILD.
  - cfg_we and build_start in the same cycle: the write commits at that edge and is visible to the build.
- BUILD (busy = 1), one entry per cycle:
  - v = fwd[i].
  - If seen[v] = 1: err_dup <= 1, go to IDLE immediately (abort).
  - Else: inv[v] <= i, seen[v] <= 1.
  - If i == N-1 and no duplicate: go to READY. Otherwise i <= i+1.
- BUILD inputs ignored: cfg_we, build_start and lk_valid have no effect.
- Build timing for a valid permutation:
  - busy is high for exactly N cycles after the edge that samples build_start.
  - done rises on the edge after index N-1 is processed.
- Build timing for a duplicate at index k: busy is high for k+1 cycles, then err_dup = 1 and done = 0.
- err_dup holds until the next accepted build_start or reset.
- READY (done = 1, lk_ready = 1):
  - Lookup: when lk_valid = 1, at the next edge out <= inv[lk_in] and out_valid <= 1.
  - Otherwise out_valid <= 0. out holds its last value.
  - Throughput is one lookup per cycle.
- READY, cfg_we:
  - Writes fwd, sets done <= 0, goes to IDLE. A rebuild is required.
  - A lookup in the same cycle is still served from the old inv.
- READY, build_start (without cfg_we): rebuild; done <= 0, go to BUILD.
- The inverse is assembled by construction, so no arithmetic beyond i+1 is needed. The counter never wraps, because BUILD exits at N-1.
- A bijection is guaranteed when all N entries pass the seen check (pigeonhole), so no separate completeness check is needed.

Decomposition:
- Package gost34_12_2015_pkg:
  - localparam SBOX_W = 8.
  - typedef logic [SBOX_W-1:0] sbox_word_t.
  - FSM enum inv_state_t {IDLE, BUILD, READY}.
  - The Kuznyechik pi constant array, shared with the forward path and with benches.
- Sub-module: gost34_12_2015_inv_sbox_ram, holding the N x W inverse store.
  - Synchronous write port.
  - Registered read port; this read port provides the 1-cycle lookup latency.

Test Plan:
1. Identity load (fwd[x] = x), build -> busy high exactly 256 cycles, done = 1, err_dup = 0. Lookups 0x00, 0x7F, 0xFF return the same values, out_valid 1 cycle after lk_valid.
2. Kuznyechik pi load (pi[0] = 0xFC, pi[1] = 0xEE, pi[255] = 0xB6), build -> lookups 0xFC -> 0x00, 0xEE -> 0x01, 0xB6 -> 0xFF. Then 256 back-to-back lookups of all y -> pi(out) = y on every cycle.
3. Identity with fwd[5] = 0x03, build -> abort at i = 5 (busy high 6 cycles), err_dup = 1, done = 0, lk_ready = 0. Rewrite fwd[5] = 0x05 and rebuild -> err_dup clears at start, done = 1 after 256 cycles.
4. rst asserted at cycle 100 of BUILD -> outputs 0 immediately (asynchronous), FSM in IDLE. Lookup with lk_valid = 1 -> no out_valid.
5. In READY, cfg_we (addr 0x00, data 0x01) together with lk_valid (lk_in = 0xFC, pi loaded) -> out = 0x00, out_valid = 1, then done = 0 and subsequent lookups are not accepted.
6. In IDLE, cfg_we (addr 0xFF, data 0xB6) plus build_start in the same cycle, on a table with pi[255] previously cleared -> build uses 0xB6, done = 1, lookup 0xB6 -> 0xFF.
